button_event_conditioner: RTL and testbench
===========================================

// Module: button_event_conditioner
// PURPOSE
//  Input-side front end for the chess timer. Turns raw, bouncy player inputs into
//  clean levels, single-cycle press strobes and a held valid/ack event stream for
//  FSM_ChessTimer. It sits between the board switches/keys and the control FSM, in
//  place of wiring SW[1:0] straight into the FSM. Everything runs on the 50 MHz clock.
// PARAMETERS
//  N_CH             2        number of player inputs (channel 0 = player 1)
//  ID_W             1        width of o_evt_id, must satisfy 2**ID_W >= N_CH
//  DEBOUNCE_CYCLES  500000   consecutive stable cycles needed to accept a level (10 ms)
//  CNT_W            19       debounce counter width, must satisfy 2**CNT_W >= DEBOUNCE_CYCLES
// PORTS
//  i_clk          in   1      system clock (MAX10_CLK1_50)
//  i_reset_n      in   1      reset, asynchronous assert, active-low
//  i_raw          in   N_CH   raw asynchronous button/switch levels, active-high
//  i_ack          in   1      FSM accepts the current event
//  o_level        out  N_CH   debounced level per channel
//  o_press_pulse  out  N_CH   1-cycle strobe on each debounced 0->1 transition
//  o_evt_valid    out  1      event available; held until acknowledged
//  o_evt_id       out  ID_W   channel index of the event; stable while o_evt_valid=1
//  o_drop         out  1      1-cycle strobe: a press was merged into an already-pending request
// BEHAVIOUR
//  Reset: i_reset_n=0 clears everything asynchronously.
//   - Outputs: o_level, o_press_pulse, o_evt_valid, o_evt_id and o_drop all go to 0.
//   - Internal state: synchronizers, counters and pending bits clear; FSM goes to IDLE.
//  Sync: each i_raw bit passes through a 2-flop synchronizer (s1, s2).
//  Debounce, per channel:
//   - If s2 == o_level, the counter clears to 0.
//   - Otherwise the counter increments.
//   - If the counter == DEBOUNCE_CYCLES-1 and s2 still differs, o_level <= s2 and the
//     counter clears.
//   - Latency: raw change set up before edge 1 -> o_level updates on edge 2+DEBOUNCE_CYCLES.
//   - Any mismatch gap (s2 returns to o_level) restarts the count from 0.
//  Press strobe: o_press_pulse[i] goes high on the same edge o_level[i] goes 0->1.
//   - High for exactly one cycle.
//   - No strobe on 1->0 transitions.
//  Pending bits: pend[i] is set by o_press_pulse[i].
//   - If pend[i] is already 1, or channel i is the event currently held valid, the press
//     is merged and o_drop pulses for 1 cycle on the next edge.
//  Event FSM:
//   - IDLE: if any pend bit is set, select the lowest index i, clear pend[i],
//     set o_evt_id <= i and o_evt_valid <= 1, go to HOLD.
//   - HOLD: o_evt_valid and o_evt_id are held. When i_ack=1 is sampled, o_evt_valid <= 0
//     and go to GAP.
//   - GAP: one cycle with o_evt_valid=0, then go to IDLE. Back-to-back events are
//     therefore separated by at least 1 low cycle.
//   - i_ack is ignored outside HOLD.
//   - A press strobe and a selection in the same cycle on different channels: the
//     strobe sets its pend bit and it is served later.
//   - A press strobe on the same channel as the IDLE selection that cycle: merged,
//     o_drop pulses.
//  Simultaneous presses: both pend bits set; lowest index is served first, the other
//  follows after ack+GAP. No press is lost unless merged.
//  Reset mid-operation: pending requests and any valid event are discarded. A button
//  held through reset produces a fresh press 2+DEBOUNCE_CYCLES edges after release of
//  reset, because o_level restarts at 0.
//  Counter wrap: impossible. The counter clears at DEBOUNCE_CYCLES-1 and never exceeds it.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1 Bounce: i_raw[0] toggles every 2 cycles for 10 cycles, then stays 1 -> exactly one
//    press; o_level[0] rises on edge 6 after the last toggle; evt_valid=1, id=0.
//  2 Glitch: i_raw[1] high for 3 cycles, then low -> o_level, press_pulse and evt_valid
//    stay 0.
//  3 Simultaneous: i_raw=2'b11 in the same cycle -> event id=0; ack; 1 low cycle; event
//    id=1; ack; valid stays 0.
//  4 Hold: no ack for 100 cycles -> valid=1, id=0 stable; re-press ch0 meanwhile ->
//    o_drop pulses once, no second event after ack.
//  5 Reset: assert i_reset_n=0 while valid=1 and pend[1]=1 -> all outputs 0 with no
//    clock edge; release with i_raw[0]=1 held -> press_pulse[0] on edge 6.
//  6 Release: i_raw[0] 1->0 stable -> o_level[0] falls on edge 6; no press_pulse, no
//    event, no o_drop.

Source files
------------

// File: rtl/button_event_conditioner.sv
// button_event_conditioner: synchronizes and debounces raw player inputs, emits press strobes
// and a held valid/ack event stream with lowest-index priority and merge reporting.
module button_event_conditioner #(
    parameter int N_CH            = 2,
    parameter int ID_W            = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [N_CH-1:0]   i_raw,
    input  logic              i_ack,
    output logic [N_CH-1:0]   o_level,
    output logic [N_CH-1:0]   o_press_pulse,
    output logic              o_evt_valid,
    output logic [ID_W-1:0]   o_evt_id,
    output logic              o_drop
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
    state_t            state, state_d;
    logic [N_CH-1:0]   s1, s2, pend, pend_d, held, merge, clr;
    logic [CNT_W-1:0]  cnt [N_CH];
    logic              valid_d;
    logic [ID_W-1:0]   id_d;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1            <= '0;
            s2            <= '0;
            o_level       <= '0;
            o_press_pulse <= '0;
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else begin
            s1 <= i_raw;
            s2 <= s1;
            for (int i = 0; i < N_CH; i++) begin
                o_press_pulse[i] <= 1'b0;
                if (s2[i] == o_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    cnt[i]           <= '0;
                    o_level[i]       <= s2[i];
                    o_press_pulse[i] <= s2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
    // a press on a channel already pending or currently held is merged, not queued
    always_comb begin
        state_d = state;
        valid_d = o_evt_valid;
        id_d    = o_evt_id;
        clr     = '0;
        for (int i = 0; i < N_CH; i++) held[i] = o_evt_valid && (o_evt_id == ID_W'(i));
        case (state)
            IDLE: if (|pend) begin
                for (int i = N_CH - 1; i >= 0; i--) if (pend[i]) id_d = ID_W'(i);
                clr     = N_CH'(1) << id_d;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: if (i_ack) begin
                valid_d = 1'b0;
                state_d = GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        merge  = pend | held;
        pend_d = (pend & ~clr) | (o_press_pulse & ~merge);
    end
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            pend        <= '0;
            o_evt_valid <= 1'b0;
            o_evt_id    <= '0;
            o_drop      <= 1'b0;
        end else begin
            state       <= state_d;
            pend        <= pend_d;
            o_evt_valid <= valid_d;
            o_evt_id    <= id_d;
            o_drop      <= |(o_press_pulse & merge);
        end
    end
endmodule

// File: tb/tb_button_event_conditioner.sv
// tb_button_event_conditioner: directed scenarios checked every cycle against a
// history-based behavioural model, plus hand-computed literal expectations.
module tb_button_event_conditioner;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] raw;
    logic       ack;
    logic [1:0] level, pulse;
    logic       valid, id, drop;
    int         checks = 0;
    int         errors = 0;
    bit         run = 1'b0;
    int         pc0 = 0, pc1 = 0, drops = 0;

    button_event_conditioner #(.N_CH(2), .ID_W(1), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_raw(raw), .i_ack(ack),
        .o_level(level), .o_press_pulse(pulse), .o_evt_valid(valid),
        .o_evt_id(id), .o_drop(drop)
    );

    always #5 clk = ~clk;

    // model: a level flips once its synchronized input has disagreed with it for the last
    // 4 sampled cycles; events need 2 edges of quiet after an ack before the next one rises
    logic [1:0] m_level, m_pulse, m_pend, rawh [5];
    logic       m_valid, m_id, m_drop;
    int         m_quiet;
    logic [1:0] t_merge, t_clr, t_nlevel;
    logic       t_sel, t_go, t_stable;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_level = 0; m_pulse = 0; m_pend = 0; m_valid = 0; m_id = 0; m_drop = 0; m_quiet = 1;
            for (int j = 0; j < 5; j++) rawh[j] = 0;
        end else begin
            t_merge = m_pend | (m_valid ? (2'b01 << m_id) : 2'b00);
            t_go    = !m_valid && m_quiet >= 1 && m_pend != 0;
            t_sel   = m_pend[0] ? 1'b0 : 1'b1;
            t_clr   = t_go ? (2'b01 << t_sel) : 2'b00;
            m_drop  = |(m_pulse & t_merge);
            m_pend  = (m_pend & ~t_clr) | (m_pulse & ~t_merge);
            if (m_valid) begin
                if (ack) begin m_valid = 0; m_quiet = 0; end
            end else if (t_go) begin
                m_valid = 1; m_id = t_sel;
            end else if (m_quiet < 1) begin
                m_quiet = m_quiet + 1;
            end
            for (int c = 0; c < 2; c++) begin
                t_stable = 1;
                for (int j = 1; j <= 4; j++) if (rawh[j][c] == m_level[c]) t_stable = 0;
                t_nlevel[c] = t_stable ? ~m_level[c] : m_level[c];
            end
            m_pulse = t_nlevel & ~m_level;
            m_level = t_nlevel;
            for (int j = 4; j > 0; j--) rawh[j] = rawh[j-1];
            rawh[0] = raw;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (run) begin
        chk("level", {6'd0, level}, {6'd0, m_level});
        chk("pulse", {6'd0, pulse}, {6'd0, m_pulse});
        chk("valid", {7'd0, valid}, {7'd0, m_valid});
        chk("drop", {7'd0, drop}, {7'd0, m_drop});
        if (m_valid) chk("id", {7'd0, id}, {7'd0, m_id});
        pc0 += int'(pulse[0]);
        pc1 += int'(pulse[1]);
        drops += int'(drop);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid();
        logic ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            tick(1);
            ok = valid;
        end
        chk("wait_valid", {7'd0, ok}, 8'd1);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("valid_after_ack", {7'd0, valid}, 8'd0);
    endtask

    initial begin
        int p0, p1, d0;
        rst_n = 1'b0; raw = 2'b00; ack = 1'b0;
        #1;
        chk("rst_out", {level, pulse, valid, id, drop, 1'b0}, 8'd0);
        tick(2);
        rst_n = 1'b1;
        run = 1'b1;
        tick(3);
        // bounce then settle high
        p0 = pc0;
        repeat (4) begin raw[0] = ~raw[0]; tick(2); end
        raw[0] = 1'b1;
        tick(5); chk("t1_level_e5", {7'd0, level[0]}, 8'd0);
        tick(1); chk("t1_level_e6", {7'd0, level[0]}, 8'd1);
        chk("t1_pulse_e6", {7'd0, pulse[0]}, 8'd1);
        tick(1); chk("t1_valid_e7", {7'd0, valid}, 8'd0);
        tick(1); chk("t1_valid_e8", {7'd0, valid}, 8'd1);
        chk("t1_id", {7'd0, id}, 8'd0);
        tick(3); chk("t1_one_press", 8'(pc0 - p0), 8'd1);
        do_ack();
        // release
        p0 = pc0; d0 = drops;
        raw[0] = 1'b0;
        tick(5); chk("t6_level_e5", {7'd0, level[0]}, 8'd1);
        tick(1); chk("t6_level_e6", {7'd0, level[0]}, 8'd0);
        tick(4);
        chk("t6_no_evt", {7'd0, valid}, 8'd0);
        chk("t6_no_pulse", 8'(pc0 - p0), 8'd0);
        chk("t6_no_drop", 8'(drops - d0), 8'd0);
        // glitch
        p1 = pc1;
        raw[1] = 1'b1; tick(3); raw[1] = 1'b0; tick(10);
        chk("t2_level", {6'd0, level}, 8'd0);
        chk("t2_no_pulse", 8'(pc1 - p1), 8'd0);
        chk("t2_no_evt", {7'd0, valid}, 8'd0);
        // simultaneous
        raw = 2'b11;
        wait_valid(); chk("t3_id0", {7'd0, id}, 8'd0);
        do_ack();
        tick(1); chk("t3_gap", {7'd0, valid}, 8'd0);
        wait_valid(); chk("t3_id1", {7'd0, id}, 8'd1);
        do_ack();
        tick(10); chk("t3_done", {7'd0, valid}, 8'd0);
        raw = 2'b00; tick(8);
        // hold with re-press on the held channel
        raw[0] = 1'b1;
        wait_valid();
        d0 = drops;
        for (int n = 0; n < 100; n++) begin
            if (n == 10) raw[0] = 1'b0;
            if (n == 30) raw[0] = 1'b1;
            tick(1);
        end
        chk("t4_valid_held", {7'd0, valid}, 8'd1);
        chk("t4_id_held", {7'd0, id}, 8'd0);
        chk("t4_one_drop", 8'(drops - d0), 8'd1);
        do_ack();
        tick(20); chk("t4_no_second", {7'd0, valid}, 8'd0);
        raw = 2'b00; tick(8);
        // reset while an event is held and channel 1 is pending
        raw = 2'b11;
        wait_valid();
        raw[1] = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("t5_rst_out", {level, pulse, valid, id, drop, 1'b0}, 8'd0);
        tick(1);
        rst_n = 1'b1;
        tick(5); chk("t5_pulse_e5", {7'd0, pulse[0]}, 8'd0);
        tick(1); chk("t5_pulse_e6", {7'd0, pulse[0]}, 8'd1);
        wait_valid(); chk("t5_id", {7'd0, id}, 8'd0);
        do_ack();
        tick(10); chk("t5_pend_discarded", {7'd0, valid}, 8'd0);
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
